axi_sram_slave: RTL and testbench

AXI3/AXI4-subset responder backed by an on-chip word-addressed SRAM with byte-strobe writes. It is the slave end of the 32-bit AXI master port that the CPU's cache interface drives. It lets the core and its caches run against a synthesizable memory in simulation and FPGA bring-up without the SoC crossbar. It serves one transaction at a time with INCR/FIXED bursts; writes win arbitration over reads.

---
 rtl/axi_sram_pkg.sv | 49 ++++
 rtl/sram_bytewe.sv | 44 ++++
 rtl/axi_sram_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_pkg
// Shared types and constants for the AXI SRAM responder: the control FSM
// state encoding, AXI response/burst/size codes, and small helpers for
// transfer-size clamping and burst address stepping.
// ---------------------------------------------------------------------------
package axi_sram_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_FETCH = 3'd1,
      RD_DATA  = 3'd2,
      WR_DATA  = 3'd3,
      WR_RESP  = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [2:0] SIZE_WORD   = 3'd2;

   // The data path is one 32-bit word wide, so wider beat sizes collapse to a word.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      logic [2:0] res;
      if (size > SIZE_WORD) begin
         res = SIZE_WORD;
      end else begin
         res = size;
      end
      return res;
   endfunction

   // FIXED bursts keep hitting the same address; WRAP is handled as INCR.
   // The sum is 32 bits wide so stepping past the top of the space wraps to 0.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [31:0] res;
      case (burst)
         BURST_FIXED: res = addr;
         BURST_INCR:  res = addr + (32'd1 << size);
         BURST_WRAP:  res = addr + (32'd1 << size);
         default:     res = addr + (32'd1 << size);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sram_bytewe.sv
// ---------------------------------------------------------------------------
// sram_bytewe
// Single-port word-addressed SRAM with four byte-lane write enables and a
// synchronous, enable-qualified read port. The read register only updates
// when ren is high, so the last fetched word is held while the consumer
// stalls. Contents are not reset.
// Ports:
//   aclk   clock
//   ren    read enable: capture mem[addr] into rdata on the clock edge
//   we     per-byte write enables (bit i writes wdata[8i+7:8i])
//   addr   word address
//   wdata  write data
//   rdata  registered read data
// ---------------------------------------------------------------------------
module sram_bytewe #(
   parameter int ADDR_BITS = 12
) (
   input  logic                 aclk,
   input  logic                 ren,
   input  logic [3:0]           we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem_r [0:(1 << ADDR_BITS)-1];

   // Byte-lane writes into the array.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Enable-qualified synchronous read; holds its value when ren is low.
   always_ff @(posedge aclk) begin
      if (ren) begin
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3/AXI4-subset responder in front of a byte-writable on-chip SRAM.
// One transaction at a time, INCR/FIXED bursts (WRAP handled as INCR),
// writes win over reads when both address channels are valid in IDLE.
// All responses are OKAY. The memory aliases modulo its size.
// Ports:
//   aclk, aresetn                     clock, async active-low reset
//   ar*  (arvalid/arready)            read address channel
//   r*   (rvalid/rready)              read data channel
//   aw*  (awvalid/awready)            write address channel
//   w*   (wvalid/wready)              write data channel (wid, wlast unused)
//   b*   (bvalid/bready)              write response channel
//   ar/aw lock, cache, prot           accepted and unused
// ---------------------------------------------------------------------------
module axi_sram_slave
   import axi_sram_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic        aclk,
   input  logic        aresetn,
   // read address
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   state_e      state_r;
   logic        rst_done_r;
   logic [3:0]  id_r;
   logic [31:0] addr_r;
   logic [7:0]  len_r;
   logic [2:0]  size_r;
   logic [1:0]  burst_r;
   logic [7:0]  count_r;
   logic        rvalid_r;
   logic        rlast_r;
   logic [3:0]  rid_r;
   logic        wready_r;
   logic        bvalid_r;
   logic [3:0]  bid_r;

   logic        idle_s;
   logic        aw_hs_s;
   logic        ar_hs_s;
   logic        r_hs_s;
   logic        w_beat_s;
   logic        b_hs_s;
   logic        sram_ren_s;
   logic [3:0]  sram_we_s;
   logic [31:0] sram_q_s;
   logic        unused_s;

   // Protocol fields this responder accepts but never acts on.
   assign unused_s = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast};

   // Ready gating: nothing is accepted until one clock after reset release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rst_done_r <= 1'b0;
      end else begin
         rst_done_r <= 1'b1;
      end
   end

   assign idle_s   = (state_r == IDLE);
   // arready is masked by awvalid so a same-cycle write request wins.
   assign awready  = rst_done_r & idle_s;
   assign arready  = rst_done_r & idle_s & ~awvalid;

   assign aw_hs_s  = awvalid & awready;
   assign ar_hs_s  = arvalid & arready;
   assign r_hs_s   = rvalid_r & rready;
   assign w_beat_s = wready_r & wvalid;
   assign b_hs_s   = bvalid_r & bready;

   assign rvalid   = rvalid_r;
   assign rlast    = rlast_r;
   assign rid      = rid_r;
   assign rresp    = RESP_OKAY;
   assign wready   = wready_r;
   assign bvalid   = bvalid_r;
   assign bid      = bid_r;
   assign bresp    = RESP_OKAY;

   // SRAM control: fetch in RD_FETCH, byte-enabled write on each accepted W beat.
   always_comb begin
      sram_ren_s = (state_r == RD_FETCH);
      if (w_beat_s) begin
         sram_we_s = wstrb;
      end else begin
         sram_we_s = 4'b0000;
      end
   end

   // The SRAM read register has no reset, so rdata is forced to zero outside a beat.
   always_comb begin
      if (rvalid_r) begin
         rdata = sram_q_s;
      end else begin
         rdata = 32'h0000_0000;
      end
   end

   sram_bytewe #(
      .ADDR_BITS (ADDR_BITS)
   ) u_sram (
      .aclk  (aclk),
      .ren   (sram_ren_s),
      .we    (sram_we_s),
      .addr  (addr_r[ADDR_BITS+1:2]),
      .wdata (wdata),
      .rdata (sram_q_s)
   );

   // Transaction FSM with address/length/beat-count registers and channel outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r  <= IDLE;
         id_r     <= 4'h0;
         addr_r   <= 32'h0000_0000;
         len_r    <= 8'h00;
         size_r   <= 3'd0;
         burst_r  <= 2'b00;
         count_r  <= 8'h00;
         rvalid_r <= 1'b0;
         rlast_r  <= 1'b0;
         rid_r    <= 4'h0;
         wready_r <= 1'b0;
         bvalid_r <= 1'b0;
         bid_r    <= 4'h0;
      end else begin
         case (state_r)
            IDLE: begin
               if (aw_hs_s) begin
                  id_r     <= awid;
                  addr_r   <= awaddr;
                  len_r    <= {4'h0, awlen};
                  size_r   <= clamp_size(awsize);
                  burst_r  <= awburst;
                  count_r  <= 8'h00;
                  wready_r <= 1'b1;
                  state_r  <= WR_DATA;
               end else if (ar_hs_s) begin
                  id_r     <= arid;
                  addr_r   <= araddr;
                  len_r    <= arlen;
                  size_r   <= clamp_size(arsize);
                  burst_r  <= arburst;
                  count_r  <= 8'h00;
                  state_r  <= RD_FETCH;
               end else begin
                  state_r  <= IDLE;
               end
            end

            RD_FETCH: begin
               // SRAM word lands in its read register on this edge.
               rvalid_r <= 1'b1;
               rlast_r  <= (count_r == len_r);
               rid_r    <= id_r;
               state_r  <= RD_DATA;
            end

            RD_DATA: begin
               if (r_hs_s) begin
                  rvalid_r <= 1'b0;
                  rlast_r  <= 1'b0;
                  if (rlast_r) begin
                     state_r <= IDLE;
                  end else begin
                     count_r <= count_r + 8'd1;
                     addr_r  <= next_addr(addr_r, size_r, burst_r);
                     state_r <= RD_FETCH;
                  end
               end else begin
                  state_r <= RD_DATA;
               end
            end

            WR_DATA: begin
               // Burst ends on beat count alone; wlast is not consulted.
               if (w_beat_s) begin
                  if (count_r == len_r) begin
                     wready_r <= 1'b0;
                     bvalid_r <= 1'b1;
                     bid_r    <= id_r;
                     state_r  <= WR_RESP;
                  end else begin
                     count_r  <= count_r + 8'd1;
                     addr_r   <= next_addr(addr_r, size_r, burst_r);
                     state_r  <= WR_DATA;
                  end
               end else begin
                  state_r <= WR_DATA;
               end
            end

            WR_RESP: begin
               if (b_hs_s) begin
                  bvalid_r <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  state_r  <= WR_RESP;
               end
            end

            default: begin
               rvalid_r <= 1'b0;
               rlast_r  <= 1'b0;
               wready_r <= 1'b0;
               bvalid_r <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

   logic        aclk;
   logic        aresetn;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int          total;
   int          bad;
   logic [31:0] wbuf [0:3];
   logic [31:0] ebuf [0:3];

   axi_sram_slave dut (
      .aclk    (aclk),    .aresetn (aresetn),
      .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),
      .arsize  (arsize),  .arburst (arburst), .arlock  (arlock),
      .arcache (arcache), .arprot  (arprot),  .arvalid (arvalid),
      .arready (arready),
      .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),
      .rlast   (rlast),   .rvalid  (rvalid),  .rready  (rready),
      .awid    (awid),    .awaddr  (awaddr),  .awlen   (awlen),
      .awsize  (awsize),  .awburst (awburst), .awlock  (awlock),
      .awcache (awcache), .awprot  (awprot),  .awvalid (awvalid),
      .awready (awready),
      .wid     (wid),     .wdata   (wdata),   .wstrb   (wstrb),
      .wlast   (wlast),   .wvalid  (wvalid),  .wready  (wready),
      .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),
      .bready  (bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Full write transaction using wbuf[0..len]; optionally raises wlast on beat 0.
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input bit early_last);
      int n;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 40) begin tick(); n++; end
      chk_eq("awready", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      chk_eq("wready_after_aw", 32'(wready), 32'd1);
      chk_eq("arready_busy", 32'(arready), 32'd0);
      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
         wlast  = (b == int'(len)) || (early_last && b == 0);
         n = 0;
         while (!wready && n < 40) begin tick(); n++; end
         chk_eq("wready_beat", 32'(wready), 32'd1);
         tick();
         if (b != int'(len)) chk_eq("no_early_b", 32'(bvalid), 32'd0);
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk_eq("bvalid", 32'(bvalid), 32'd1);
      chk_eq("bid", 32'(bid), 32'(id));
      chk_eq("bresp", 32'(bresp), 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk_eq("bvalid_clr", 32'(bvalid), 32'd0);
   endtask

   // Full read transaction checked against ebuf[0..len]; beat stall_beat is held off stall_n cycles.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_n);
      int n;
      arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 40) begin tick(); n++; end
      chk_eq("arready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         // Handshake edge -> RD_FETCH cycle (rvalid low) -> RD_DATA: one extra edge.
         n = 0;
         while (!rvalid && n < 20) begin tick(); n++; end
         chk_eq("rd_lat", 32'(n), 32'd1);
         chk_eq("rdata", rdata, ebuf[b]);
         chk_eq("rlast", 32'(rlast), 32'(b == int'(len)));
         chk_eq("rid", 32'(rid), 32'(id));
         chk_eq("rresp", 32'(rresp), 32'd0);
         if (b == stall_beat) begin
            for (int k = 0; k < stall_n; k++) begin
               tick();
               chk_eq("rd_hold_valid", 32'(rvalid), 32'd1);
               chk_eq("rd_hold_data", rdata, ebuf[b]);
               chk_eq("rd_hold_last", 32'(rlast), 32'(b == int'(len)));
            end
         end
         rready = 1'b1;
         tick();
         rready = 1'b0;
      end
      chk_eq("rvalid_end", 32'(rvalid), 32'd0);
      chk_eq("idle_after_rd", 32'(arready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      total = 0; bad = 0;
      aresetn = 1'b0;
      arid = 4'h0; araddr = 32'h0; arlen = 8'h0; arsize = 3'd0; arburst = 2'b00;
      arlock = 2'b00; arcache = 4'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
      awid = 4'h0; awaddr = 32'h0; awlen = 4'h0; awsize = 3'd0; awburst = 2'b00;
      awlock = 2'b00; awcache = 4'h0; awprot = 3'd0; awvalid = 1'b0;
      wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

      // Reset state.
      tick(); tick();
      chk_eq("rst_arready", 32'(arready), 32'd0);
      chk_eq("rst_awready", 32'(awready), 32'd0);
      chk_eq("rst_rvalid", 32'(rvalid), 32'd0);
      chk_eq("rst_wready", 32'(wready), 32'd0);
      chk_eq("rst_bvalid", 32'(bvalid), 32'd0);
      chk_eq("rst_rlast", 32'(rlast), 32'd0);
      chk_eq("rst_rdata", rdata, 32'h0);
      aresetn = 1'b1;
      #1;
      chk_eq("rel_arready0", 32'(arready), 32'd0);
      tick();
      chk_eq("rel_arready1", 32'(arready), 32'd1);
      chk_eq("rel_awready1", 32'(awready), 32'd1);

      // Single write then read.
      wbuf[0] = 32'hDEADBEEF;
      do_write(4'h3, 32'h0000_0100, 4'd0, 2'b01, 4'hF, 1'b0);
      ebuf[0] = 32'hDEADBEEF;
      do_read(4'h5, 32'h0000_0100, 8'd0, 2'b01, -1, 0);
      // Address bits above the array alias: 16 KiB + 0x100 hits the same word.
      do_read(4'h6, 32'h0000_4100, 8'd0, 2'b01, -1, 0);

      // Byte strobes.
      wbuf[0] = 32'h11223344;
      do_write(4'h1, 32'h0000_0200, 4'd0, 2'b01, 4'hF, 1'b0);
      wbuf[0] = 32'hAABBCCDD;
      do_write(4'h2, 32'h0000_0200, 4'd0, 2'b01, 4'h5, 1'b0);
      ebuf[0] = 32'h11BB33DD;
      do_read(4'h7, 32'h0000_0200, 8'd0, 2'b01, -1, 0);

      // INCR burst preload and read, stalling beat 2 (index 1) for 3 cycles.
      wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
      do_write(4'h4, 32'h0000_0300, 4'd3, 2'b01, 4'hF, 1'b0);
      ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
      do_read(4'h9, 32'h0000_0300, 8'd3, 2'b01, 1, 3);

      // Simultaneous AW and AR in IDLE: the write wins and the read sees new data.
      arid = 4'hA; araddr = 32'h0000_0100; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2;
      arvalid = 1'b1;
      awid = 4'hB; awaddr = 32'h0000_0100; awlen = 4'd0; awburst = 2'b01; awsize = 3'd2;
      awvalid = 1'b1;
      #1;
      chk_eq("prio_awready", 32'(awready), 32'd1);
      chk_eq("prio_arready", 32'(arready), 32'd0);
      wbuf[0] = 32'hCAFE_F00D;
      #1;
      do_write(4'hB, 32'h0000_0100, 4'd0, 2'b01, 4'hF, 1'b0);
      ebuf[0] = 32'hCAFE_F00D;
      do_read(4'hA, 32'h0000_0100, 8'd0, 2'b01, -1, 0);

      // FIXED write burst with early wlast: one response, last data wins.
      wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
      do_write(4'hC, 32'h0000_0400, 4'd2, 2'b00, 4'hF, 1'b1);
      ebuf[0] = 32'd7;
      do_read(4'hD, 32'h0000_0400, 8'd0, 2'b01, -1, 0);

      // Reset during RD_DATA of a 4-beat burst.
      wbuf[0] = 32'hA0A0_0001; wbuf[1] = 32'hA0A0_0002; wbuf[2] = 32'hA0A0_0003; wbuf[3] = 32'hA0A0_0004;
      do_write(4'h2, 32'h0000_0500, 4'd3, 2'b01, 4'hF, 1'b0);
      arid = 4'hE; araddr = 32'h0000_0500; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 40) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      chk_eq("rst_mid_beat0", rdata, 32'hA0A0_0001);
      aresetn = 1'b0;
      #1;
      chk_eq("rst_mid_rvalid", 32'(rvalid), 32'd0);
      chk_eq("rst_mid_rid", 32'(rid), 32'd0);
      chk_eq("rst_mid_arready", 32'(arready), 32'd0);
      tick(); tick();
      aresetn = 1'b1;
      #1;
      chk_eq("rst_mid_rel0", 32'(arready), 32'd0);
      tick();
      chk_eq("rst_mid_rel1", 32'(arready), 32'd1);
      ebuf[0] = 32'hA0A0_0001; ebuf[1] = 32'hA0A0_0002; ebuf[2] = 32'hA0A0_0003; ebuf[3] = 32'hA0A0_0004;
      do_read(4'hF, 32'h0000_0500, 8'd3, 2'b01, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
